// File: rtl/cpu_fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage.
// Fetch FSM states, fault causes and the reset instruction word.
package cpu_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FAULT
   } fetch_state_t;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      MISALIGN = 2'd1,
      BUS_ERR  = 2'd2,
      TIMEOUT  = 2'd3
   } fetch_cause_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/cpu_fetch_unit.sv
// Fetch stage: PC, old PC, instruction register and ibus req/ack handshake.
// Define CPU_FETCH_TIMEOUT_EN to abort fetches that wait TIMEOUT_CYCLES.
module cpu_fetch_unit
   import cpu_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_wr_en,
   input  logic        pc_wr_en,
   input  logic [31:0] pc_next,
   input  logic        fault_clr,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_ack,
   input  logic        ibus_err,
   input  logic [31:0] ibus_rdata,
   output logic [31:0] pc,
   output logic [31:0] old_pc,
   output logic [31:0] instr,
   output logic [6:0]  opc,
   output logic [2:0]  funct3,
   output logic        funct7,
   output logic        instr_valid,
   output logic        fetch_busy,
   output logic        fetch_fault,
   output logic [1:0]  fault_cause
);

   fetch_state_t state, state_d;
   fetch_cause_t cause_q, cause_d;
   logic         req_d;
   logic [31:0]  addr_d;
   logic [31:0]  instr_d;
   logic [31:0]  old_pc_d;
   logic         valid_d;
   logic         fault_d;

`ifdef CPU_FETCH_TIMEOUT_EN
   logic [7:0]   wait_cnt, wait_cnt_d;
   logic         wait_expired;

   assign wait_expired = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   logic         unused_timeout;

   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

   always_comb begin
      state_d  = state;
      req_d    = ibus_req;
      addr_d   = ibus_addr;
      instr_d  = instr;
      old_pc_d = old_pc;
      valid_d  = 1'b0;
      fault_d  = fetch_fault;
      cause_d  = cause_q;
`ifdef CPU_FETCH_TIMEOUT_EN
      wait_cnt_d = wait_cnt;
`endif
      // Clear first so a fault raised below in the same cycle wins.
      if (fault_clr) begin
         fault_d = 1'b0;
         cause_d = NONE;
      end
      unique case (state)
         IDLE: begin
            if (instr_wr_en && !fetch_fault) begin
               if (pc[1:0] != 2'b00) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
                  cause_d = MISALIGN;
               end else begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  addr_d  = pc;
`ifdef CPU_FETCH_TIMEOUT_EN
                  wait_cnt_d = 8'd0;
`endif
               end
            end
         end
         REQ: begin
            if (ibus_err) begin
               state_d = FAULT;
               req_d   = 1'b0;
               fault_d = 1'b1;
               cause_d = BUS_ERR;
            end else if (ibus_ack) begin
               state_d  = IDLE;
               req_d    = 1'b0;
               instr_d  = ibus_rdata;
               old_pc_d = ibus_addr;
               valid_d  = 1'b1;
`ifdef CPU_FETCH_TIMEOUT_EN
            end else if (wait_expired) begin
               state_d = FAULT;
               req_d   = 1'b0;
               fault_d = 1'b1;
               cause_d = TIMEOUT;
            end else begin
               wait_cnt_d = wait_cnt + 8'd1;
`endif
            end
         end
         FAULT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         old_pc      <= RESET_PC;
         instr       <= NOP_INSTR;
         ibus_req    <= 1'b0;
         ibus_addr   <= 32'h0;
         instr_valid <= 1'b0;
         fetch_fault <= 1'b0;
         cause_q     <= NONE;
      end else begin
         state       <= state_d;
         old_pc      <= old_pc_d;
         instr       <= instr_d;
         ibus_req    <= req_d;
         ibus_addr   <= addr_d;
         instr_valid <= valid_d;
         fetch_fault <= fault_d;
         cause_q     <= cause_d;
         if (pc_wr_en) begin
            pc <= pc_next;
         end
      end
   end

`ifdef CPU_FETCH_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 8'd0;
      end else begin
         wait_cnt <= wait_cnt_d;
      end
   end
`endif

   assign fetch_busy  = (state == REQ);
   assign fault_cause = cause_q;
   assign opc         = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[30];

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboard bench for cpu_fetch_unit: captures and faults are queued
// by the stimulus and checked by monitors when the DUT reports them.
module tb_cpu_fetch_unit;
   import cpu_fetch_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        instr_wr_en;
   logic        pc_wr_en;
   logic [31:0] pc_next;
   logic        fault_clr;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ack;
   logic        ibus_err;
   logic [31:0] ibus_rdata;
   logic [31:0] pc;
   logic [31:0] old_pc;
   logic [31:0] instr;
   logic [6:0]  opc;
   logic [2:0]  funct3;
   logic        funct7;
   logic        instr_valid;
   logic        fetch_busy;
   logic        fetch_fault;
   logic [1:0]  fault_cause;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] old_pc;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
   } cap_t;

   cap_t       cap_q[$];
   logic [1:0] cause_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic       fault_prev;

   cpu_fetch_unit #(
      .RESET_PC      (32'h0000_0000),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr_wr_en(instr_wr_en),
      .pc_wr_en   (pc_wr_en),
      .pc_next    (pc_next),
      .fault_clr  (fault_clr),
      .ibus_req   (ibus_req),
      .ibus_addr  (ibus_addr),
      .ibus_ack   (ibus_ack),
      .ibus_err   (ibus_err),
      .ibus_rdata (ibus_rdata),
      .pc         (pc),
      .old_pc     (old_pc),
      .instr      (instr),
      .opc        (opc),
      .funct3     (funct3),
      .funct7     (funct7),
      .instr_valid(instr_valid),
      .fetch_busy (fetch_busy),
      .fetch_fault(fetch_fault),
      .fault_cause(fault_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cap(input logic [31:0] i, input logic [31:0] op,
                           input logic [6:0] o, input logic [2:0] f3,
                           input logic f7);
      cap_t c;
      c.instr  = i;
      c.old_pc = op;
      c.opc    = o;
      c.f3     = f3;
      c.f7     = f7;
      cap_q.push_back(c);
   endtask

   task automatic set_pc(input logic [31:0] v);
      pc_wr_en = 1'b1;
      pc_next  = v;
      step();
      pc_wr_en = 1'b0;
      chk("pc_load", pc, v);
   endtask

   // Capture monitor
   always @(negedge clk) begin
      if (rst_n && instr_valid) begin
         if (cap_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_valid: got instr %h expected none",
                     instr);
         end else begin
            cap_t e;
            e = cap_q.pop_front();
            chk("cap_instr", instr, e.instr);
            chk("cap_old_pc", old_pc, e.old_pc);
            chk("cap_opc", 32'(opc), 32'(e.opc));
            chk("cap_funct3", 32'(funct3), 32'(e.f3));
            chk("cap_funct7", 32'(funct7), 32'(e.f7));
         end
      end
   end

   // Fault monitor: checks cause on each new fault
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_prev <= 1'b0;
      end else begin
         fault_prev <= fetch_fault;
         if (fetch_fault && !fault_prev) begin
            if (cause_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_fault: got cause %0d expected none",
                        fault_cause);
            end else begin
               chk("fault_cause", 32'(fault_cause), 32'(cause_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      instr_wr_en = 1'b0;
      pc_wr_en    = 1'b0;
      pc_next     = 32'h0;
      fault_clr   = 1'b0;
      ibus_ack    = 1'b0;
      ibus_err    = 1'b0;
      ibus_rdata  = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_old_pc", old_pc, 32'h0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_req", 32'(ibus_req), 32'h0);
      chk("rst_addr", ibus_addr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_busy", 32'(fetch_busy), 32'h0);
      chk("rst_fault", 32'(fetch_fault), 32'h0);
      chk("rst_cause", 32'(fault_cause), 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // Zero-wait fetch at address 0
      instr_wr_en = 1'b1;
      step();
      instr_wr_en = 1'b0;
      chk("t1_req", 32'(ibus_req), 32'h1);
      chk("t1_addr", ibus_addr, 32'h0);
      chk("t1_busy", 32'(fetch_busy), 32'h1);
      ibus_ack   = 1'b1;
      ibus_rdata = 32'h0050_0093;
      push_cap(32'h0050_0093, 32'h0, 7'h13, 3'd0, 1'b0);
      step();
      ibus_ack = 1'b0;
      chk("t1_valid", 32'(instr_valid), 32'h1);
      chk("t1_req_drop", 32'(ibus_req), 32'h0);
      step();
      chk("t1_valid_pulse", 32'(instr_valid), 32'h0);

      // Four wait cycles at address 4
      set_pc(32'h4);
      instr_wr_en = 1'b1;
      step();
      instr_wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_req", 32'(ibus_req), 32'h1);
         chk("t2_addr", ibus_addr, 32'h4);
         chk("t2_busy", 32'(fetch_busy), 32'h1);
         if (i < 4) step();
      end
      ibus_ack   = 1'b1;
      ibus_rdata = 32'h4020_8133;
      push_cap(32'h4020_8133, 32'h4, 7'h33, 3'd0, 1'b1);
      step();
      ibus_ack = 1'b0;
      step();
      chk("t2_idle", 32'(fetch_busy), 32'h0);

      // Misaligned PC faults without a bus request
      set_pc(32'h0000_0102);
      instr_wr_en = 1'b1;
      cause_q.push_back(2'd1);
      step();
      instr_wr_en = 1'b0;
      chk("t3_no_req", 32'(ibus_req), 32'h0);
      chk("t3_busy", 32'(fetch_busy), 32'h0);
      chk("t3_fault", 32'(fetch_fault), 32'h1);
      step();
      instr_wr_en = 1'b1;
      step();
      instr_wr_en = 1'b0;
      chk("t3_ignored", 32'(ibus_req), 32'h0);
      chk("t3_sticky", 32'(fetch_fault), 32'h1);
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      chk("t3_cleared", 32'(fetch_fault), 32'h0);
      chk("t3_cause_none", 32'(fault_cause), 32'h0);

      // Ack and err together: err wins
      set_pc(32'h10);
      instr_wr_en = 1'b1;
      step();
      instr_wr_en = 1'b0;
      chk("t4_addr", ibus_addr, 32'h10);
      ibus_ack   = 1'b1;
      ibus_err   = 1'b1;
      ibus_rdata = 32'hdead_beef;
      cause_q.push_back(2'd2);
      step();
      ibus_ack = 1'b0;
      ibus_err = 1'b0;
      chk("t4_instr_kept", instr, 32'h4020_8133);
      chk("t4_no_valid", 32'(instr_valid), 32'h0);
      chk("t4_req_drop", 32'(ibus_req), 32'h0);
      step();
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      chk("t4_cleared", 32'(fetch_fault), 32'h0);

      // PC write during an in-flight fetch
      set_pc(32'h8);
      instr_wr_en = 1'b1;
      step();
      instr_wr_en = 1'b0;
      pc_wr_en    = 1'b1;
      pc_next     = 32'h40;
      step();
      pc_wr_en = 1'b0;
      chk("t5_addr_kept", ibus_addr, 32'h8);
      chk("t5_pc", pc, 32'h40);
      chk("t5_req", 32'(ibus_req), 32'h1);
      ibus_ack   = 1'b1;
      ibus_rdata = 32'h0020_c1b3;
      push_cap(32'h0020_c1b3, 32'h8, 7'h33, 3'd4, 1'b0);
      step();
      ibus_ack = 1'b0;
      chk("t5_pc_after", pc, 32'h40);
      step();

`ifdef CPU_FETCH_TIMEOUT_EN
      // No ack: abort after TIMEOUT_CYCLES REQ cycles
      instr_wr_en = 1'b1;
      step();
      instr_wr_en = 1'b0;
      cause_q.push_back(2'd3);
      for (int i = 0; i < 4; i++) begin
         chk("t6_req", 32'(ibus_req), 32'h1);
         step();
      end
      chk("t6_req_drop", 32'(ibus_req), 32'h0);
      chk("t6_fault", 32'(fetch_fault), 32'h1);
      ibus_ack   = 1'b1;
      ibus_rdata = 32'h1234_5678;
      step();
      ibus_ack = 1'b0;
      step();
      chk("t6_instr_kept", instr, 32'h0020_c1b3);
      chk("t6_old_pc_kept", old_pc, 32'h8);
`endif

      repeat (3) step();
      chk("cap_queue_empty", 32'(cap_q.size()), 32'h0);
      chk("cause_queue_empty", 32'(cause_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
